// File: rtl/wave_period_meter.sv
// Measures period and signed peaks of each cycle of a sample stream, using
// hysteresis-qualified rising zero-crossings as the cycle boundary.
module wave_period_meter #(
  parameter int width = 12,
  parameter int PER_W = 25,
  parameter int HYST  = 64
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic [width-1:0] sample_in,
  input  logic             sample_valid,
  output logic [PER_W-1:0] period,
  output logic [width-1:0] pos_peak,
  output logic [width-1:0] neg_peak,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

  localparam logic signed [width-1:0] HYST_P  = width'(HYST);
  localparam logic signed [width-1:0] HYST_N  = -HYST_P;
  localparam logic        [PER_W-1:0] CNT_MAX = '1;

  function automatic logic signed [width-1:0] smax(input logic signed [width-1:0] a,
                                                   input logic signed [width-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [width-1:0] smin(input logic signed [width-1:0] a,
                                                   input logic signed [width-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t                   state_q, state_d;
  logic                     pol_q, pol_d;
  logic        [PER_W-1:0]  cnt_q, cnt_d;
  logic signed [width-1:0]  max_q, max_d;
  logic signed [width-1:0]  min_q, min_d;
  logic        [PER_W-1:0]  period_q, period_d;
  logic signed [width-1:0]  pos_q, pos_d;
  logic signed [width-1:0]  neg_q, neg_d;
  logic                     mv_q, mv_d;
  logic                     to_q, to_d;

  logic signed [width-1:0]  samp;
  logic                     above, below, rise;

  assign samp  = $signed(sample_in);
  assign above = samp > HYST_P;
  assign below = samp < HYST_N;
  assign rise  = sample_valid && !pol_q && above;

  always_comb begin
    state_d  = state_q;
    pol_d    = pol_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    min_d    = min_q;
    period_d = period_q;
    pos_d    = pos_q;
    neg_d    = neg_q;
    mv_d     = 1'b0;
    to_d     = to_q;

    if (sample_valid) begin
      if (above)      pol_d = 1'b1;
      else if (below) pol_d = 1'b0;
    end

    // enable low wins over any crossing seen on the same edge
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      max_d   = '0;
      min_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          cnt_d   = '0;
          max_d   = '0;
          min_d   = '0;
        end
        S_ARM: begin
          if (rise) begin
            state_d = S_MEAS;
            cnt_d   = PER_W'(1);
            max_d   = samp;
            min_d   = samp;
          end
        end
        S_MEAS: begin
          if (rise) begin
            period_d = cnt_q;
            pos_d    = max_q;
            neg_d    = min_q;
            mv_d     = 1'b1;
            to_d     = 1'b0;
            cnt_d    = PER_W'(1);
            max_d    = samp;
            min_d    = samp;
          end else if (cnt_q == CNT_MAX) begin
            to_d    = 1'b1;
            state_d = S_ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PER_W'(1);
            if (sample_valid) begin
              max_d = smax(max_q, samp);
              min_d = smin(min_q, samp);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pol_q    <= 1'b0;
      cnt_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      period_q <= '0;
      pos_q    <= '0;
      neg_q    <= '0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pol_q    <= pol_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      min_q    <= min_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      mv_q     <= mv_d;
      to_q     <= to_d;
    end
  end

  assign period     = period_q;
  assign pos_peak   = pos_q;
  assign neg_peak   = neg_q;
  assign meas_valid = mv_q;
  assign timeout    = to_q;
  assign busy       = (state_q != S_IDLE);

endmodule
